// File: rtl/enc8to3_serial_pkg.sv
// Shared types and widths for the serial 8-to-3 encoder.
// Holds the FSM state encoding and the pending-bit clear helper.
package enc8to3_serial_pkg;

    localparam int VEC_W  = 8;
    localparam int CODE_W = 3;
    localparam int CNT_W  = 4;

    localparam logic [VEC_W-1:0] VEC_ONE = VEC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    function automatic logic [VEC_W-1:0] clear_bit(
        input logic [VEC_W-1:0]  vec,
        input logic [CODE_W-1:0] idx
    );
        return vec & ~(VEC_ONE << idx);
    endfunction

endpackage

// File: rtl/enc8to3_pri.sv
// Combinational 8-bit priority encoder: lowest (or highest) set index,
// plus any-bit-set and exactly-one-bit-set flags. idx is 0 for an empty vector.
module enc8to3_pri
    import enc8to3_serial_pkg::*;
(
    input  logic [VEC_W-1:0]  i_vec,
    input  logic              i_msb_first,
    output logic [CODE_W-1:0] o_idx,
    output logic              o_any,
    output logic              o_one
);

    // Later loop iterations win, so the scan direction sets the priority.
    always_comb begin
        o_idx = '0;
        if (i_msb_first) begin
            for (int i = 0; i < VEC_W; i++) begin
                if (i_vec[i]) o_idx = CODE_W'(i);
            end
        end else begin
            for (int i = VEC_W - 1; i >= 0; i--) begin
                if (i_vec[i]) o_idx = CODE_W'(i);
            end
        end
    end

    assign o_any = |i_vec;
    assign o_one = o_any && ((i_vec & (i_vec - VEC_ONE)) == '0);

endmodule

// File: rtl/enc8to3_serial.sv
// Sequential 8-to-3 encoder: emits the index of each set bit of an accepted
// vector, one per valid/ready beat, in priority order; an all-zero vector gives one "none" beat.
module enc8to3_serial
    import enc8to3_serial_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [VEC_W-1:0]  i_in,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic [CODE_W-1:0] o_out,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_none,
    output logic              o_out_last,
    output logic [CNT_W-1:0]  o_out_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [VEC_W-1:0]  r_pend;
    logic              r_zflag;
    logic [CNT_W-1:0]  r_cnt;

    logic [CODE_W-1:0] w_idx;
    logic              w_any;
    logic              w_one;
    logic              w_accept;
    logic              w_xfer;
    logic              w_last;

    enc8to3_pri u_pri (
        .i_vec       (r_pend),
        .i_msb_first (MSB_FIRST),
        .o_idx       (w_idx),
        .o_any       (w_any),
        .o_one       (w_one)
    );

    assign w_last = r_zflag | w_one;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs decode from registers only, so they are stable under backpressure.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_xfer      = 1'b0;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_out       = '0;
        o_out_none  = 1'b0;
        o_out_last  = 1'b0;
        o_out_cnt   = '0;
        case (r_state)
            ST_IDLE: begin
                o_in_ready = 1'b1;
                w_accept   = i_in_valid;
                if (i_in_valid) w_state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                o_out_valid = 1'b1;
                o_out       = w_any ? w_idx : '0;
                o_out_none  = r_zflag;
                o_out_last  = w_last;
                o_out_cnt   = r_cnt;
                w_xfer      = i_out_ready;
                if (i_out_ready && w_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend  <= '0;
            r_zflag <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_pend  <= i_in;
            r_zflag <= (i_in == '0);
            r_cnt   <= CNT_ONE;
        end else if (w_xfer) begin
            if (w_last) begin
                r_pend  <= '0;
                r_zflag <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_pend  <= clear_bit(r_pend, w_idx);
                r_cnt   <= r_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_enc8to3_serial.sv
// Bench for enc8to3_serial: one LSB-first and one MSB-first instance driven from
// a vector table of hand-computed beat sequences plus reset, backpressure and back-to-back cases.
module tb_enc8to3_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] in_l = '0, in_m = '0;
    logic       in_vld_l = 1'b0, in_vld_m = 1'b0;
    logic       out_rdy_l = 1'b0, out_rdy_m = 1'b0;

    logic       in_rdy_l, in_rdy_m;
    logic [2:0] out_l, out_m;
    logic       out_vld_l, out_vld_m;
    logic       none_l, none_m;
    logic       last_l, last_m;
    logic [3:0] cnt_l, cnt_m;

    logic       sel = 1'b0;
    logic       m_in_rdy, m_vld, m_none, m_last;
    logic [2:0] m_out;
    logic [3:0] m_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    enc8to3_serial #(.MSB_FIRST(1'b0)) dut_lsb (
        .i_clk(clk), .i_rst(rst), .i_in(in_l), .i_in_valid(in_vld_l),
        .o_in_ready(in_rdy_l), .o_out(out_l), .o_out_valid(out_vld_l),
        .i_out_ready(out_rdy_l), .o_out_none(none_l), .o_out_last(last_l),
        .o_out_cnt(cnt_l)
    );

    enc8to3_serial #(.MSB_FIRST(1'b1)) dut_msb (
        .i_clk(clk), .i_rst(rst), .i_in(in_m), .i_in_valid(in_vld_m),
        .o_in_ready(in_rdy_m), .o_out(out_m), .o_out_valid(out_vld_m),
        .i_out_ready(out_rdy_m), .o_out_none(none_m), .o_out_last(last_m),
        .o_out_cnt(cnt_m)
    );

    assign m_in_rdy = sel ? in_rdy_m  : in_rdy_l;
    assign m_vld    = sel ? out_vld_m : out_vld_l;
    assign m_out    = sel ? out_m     : out_l;
    assign m_none   = sel ? none_m    : none_l;
    assign m_last   = sel ? last_m    : last_l;
    assign m_cnt    = sel ? cnt_m     : cnt_l;

    typedef struct {
        logic [7:0]  vec;
        logic        msb;
        int          n;
        logic [23:0] codes;   // beat k code at [3k+2:3k]
        logic        none;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic msb, input logic vld, input logic [7:0] vec, input logic rdy);
        if (msb) begin
            in_vld_m = vld; in_m = vec; out_rdy_m = rdy;
        end else begin
            in_vld_l = vld; in_l = vec; out_rdy_l = rdy;
        end
    endtask

    task automatic chk_beat(input string tag, input int code, input int none,
                            input int last, input int cnt);
        chk({tag, " valid"}, int'(m_vld), 1);
        chk({tag, " out"},   int'(m_out), code);
        chk({tag, " none"},  int'(m_none), none);
        chk({tag, " last"},  int'(m_last), last);
        chk({tag, " cnt"},   int'(m_cnt), cnt);
    endtask

    task automatic run_vec(input int t);
        vec_t v;
        v   = tbl[t];
        sel = v.msb;
        @(negedge clk);
        chk($sformatf("v%0d in_ready before", t), int'(m_in_rdy), 1);
        drive(v.msb, 1'b1, v.vec, 1'b1);
        @(negedge clk);
        drive(v.msb, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < v.n; k++) begin
            chk_beat($sformatf("v%0d b%0d", t, k), int'(v.codes[3*k +: 3]),
                     int'(v.none), (k == v.n - 1) ? 1 : 0, k + 1);
            chk($sformatf("v%0d b%0d in_ready", t, k), int'(m_in_rdy), 0);
            @(negedge clk);
        end
        chk($sformatf("v%0d idle valid", t), int'(m_vld), 0);
        chk($sformatf("v%0d idle in_ready", t), int'(m_in_rdy), 1);
        drive(v.msb, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        tbl[0] = '{8'h24, 1'b0, 2, {18'd0, 3'd5, 3'd2}, 1'b0};
        tbl[1] = '{8'h00, 1'b0, 1, 24'd0, 1'b1};
        tbl[2] = '{8'hFF, 1'b1, 8, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 1'b0};
        tbl[4] = '{8'h5A, 1'b0, 4, {12'd0, 3'd6, 3'd4, 3'd3, 3'd1}, 1'b0};
        tbl[5] = '{8'h5A, 1'b1, 4, {12'd0, 3'd1, 3'd3, 3'd4, 3'd6}, 1'b0};
        tbl[6] = '{8'h81, 1'b1, 2, {18'd0, 3'd0, 3'd7}, 1'b0};
        tbl[7] = '{8'h00, 1'b1, 1, 24'd0, 1'b1};
        tbl[8] = '{8'h80, 1'b0, 1, {21'd0, 3'd7}, 1'b0};
        tbl[9] = '{8'h01, 1'b1, 1, 24'd0, 1'b0};

        // Reset state
        #1;
        sel = 1'b0;
        chk("rst in_ready", int'(m_in_rdy), 1);
        chk("rst valid", int'(m_vld), 0);
        chk("rst out", int'(m_out), 0);
        chk("rst cnt", int'(m_cnt), 0);
        chk("rst msb valid", int'(out_vld_m), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 10; t++) run_vec(t);

        // Reset mid-vector: outputs drop immediately, stale bits never appear
        sel = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hF0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk_beat("mr pre", 4, 0, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk("mr in_ready", int'(m_in_rdy), 1);
        chk("mr valid", int'(m_vld), 0);
        chk("mr out", int'(m_out), 0);
        chk("mr cnt", int'(m_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mr stale valid %0d", k), int'(m_vld), 0);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Backpressure on 8'h81 with a competing input held during EMIT
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h81, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h3C, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk_beat($sformatf("bp hold%0d", k), 0, 0, 0, 1);
            @(negedge clk);
        end
        drive(1'b0, 1'b1, 8'h3C, 1'b1);
        chk_beat("bp b0", 0, 0, 0, 1);
        @(negedge clk);
        chk_beat("bp b1", 7, 0, 1, 2);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("bp idle valid", int'(m_vld), 0);
        chk("bp idle in_ready", int'(m_in_rdy), 1);
        @(negedge clk);
        chk("bp no extra", int'(m_vld), 0);

        // Back-to-back 8'h08 then 8'h10: one bubble between them
        drive(1'b0, 1'b1, 8'h08, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h10, 1'b1);
        chk_beat("bb first", 3, 0, 1, 1);
        @(negedge clk);
        chk("bb bubble valid", int'(m_vld), 0);
        chk("bb bubble in_ready", int'(m_in_rdy), 1);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk_beat("bb second", 4, 0, 1, 1);
        @(negedge clk);
        chk("bb end valid", int'(m_vld), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
